// File: rtl/pdm_modulator.sv
// pdm_modulator: second-order sigma-delta PCM-to-PDM modulator with
// bit-clock divider, one-deep sample holding register and underrun flag.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   enable    run divider and modulator; low parks pdm_clk/pdm_data at 0
//   in_data   signed Q0.17 PCM sample, taken when in_valid && in_ready
//   in_valid  in_data is valid
//   in_ready  holding register is empty
//   pdm_clk   bit clock, CLK_DIV cycles per bit, low half first
//   pdm_data  bitstream, updated on the edge where pdm_clk falls
//   underrun  one-cycle pulse at a frame boundary with no new sample
module pdm_modulator #(
  parameter int CLK_DIV = 8,
  parameter int OSR     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [17:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               pdm_clk,
  output logic               pdm_data,
  output logic               underrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(OSR);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(OSR - 1);

  localparam logic signed [25:0] FS      = 26'sd131072;
  localparam logic signed [25:0] SAT_MAX = 26'sd8388607;
  localparam logic signed [25:0] SAT_MIN = -26'sd8388608;

  logic [DW-1:0]      div_cnt;
  logic [DW-1:0]      div_next;
  logic [BW-1:0]      bit_cnt;
  logic               tick;
  logic               frame_end;
  logic signed [17:0] hold;
  logic signed [17:0] cur;
  logic               hold_full;
  logic               accept;
  logic               load_cur;
  logic signed [23:0] i1;
  logic signed [23:0] i2;
  logic signed [23:0] i1_next;
  logic signed [23:0] i2_next;
  logic signed [25:0] fb;
  logic signed [25:0] i1_sum;
  logic signed [25:0] i2_sum;

  function automatic logic signed [23:0] sat24(
    input logic signed [25:0] v
  );
    logic signed [23:0] r;
    if (v > SAT_MAX)
      r = 24'sh7fffff;
    else if (v < SAT_MIN)
      r = 24'sh800000;
    else
      r = v[23:0];
    return r;
  endfunction

  assign tick      = enable && (div_cnt == DIV_LAST);
  assign frame_end = tick && (bit_cnt == BIT_LAST);
  assign div_next  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

  // pdm_clk is registered from the next divider value so it is
  // glitch-free and falls on the same edge that updates pdm_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pdm_clk <= (div_next >= DIV_HALF);
      if (tick)
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  // Feedback uses the bit currently on pdm_data (the previous bit).
  assign fb      = pdm_data ? FS : -FS;
  assign i1_sum  = 26'(i1) + 26'(cur) - fb;
  assign i1_next = sat24(i1_sum);
  assign i2_sum  = 26'(i2) + 26'(i1_next) - fb;
  assign i2_next = sat24(i2_sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1       <= '0;
      i2       <= '0;
      pdm_data <= 1'b0;
    end else if (!enable) begin
      i1       <= '0;
      i2       <= '0;
      pdm_data <= 1'b0;
    end else if (tick) begin
      i1       <= i1_next;
      i2       <= i2_next;
      pdm_data <= !i2_next[23];
    end
  end

  // accept and load_cur are exclusive: one needs an empty holding
  // register, the other a full one.  A sample arriving on the boundary
  // cycle therefore only fills the holding register.
  assign in_ready = !hold_full;
  assign accept   = in_valid && !hold_full;
  assign load_cur = frame_end && hold_full;
  assign underrun = frame_end && !hold_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      cur       <= '0;
      hold_full <= 1'b0;
    end else begin
      unique case (1'b1)
        load_cur: begin
          cur       <= hold;
          hold_full <= 1'b0;
        end
        accept: begin
          hold      <= in_data;
          hold_full <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: vector table, randomized run against an arithmetic
// reference model, and directed multi-cycle sequences for pdm_modulator.
module tb_pdm_modulator;

  localparam int CLK_DIV = 8;
  localparam int OSR     = 64;
  localparam int FRAME   = CLK_DIV * OSR;
  localparam int FS      = 131072;

  localparam logic signed [17:0] VA = 18'sd40000;
  localparam logic signed [17:0] VB = -18'sd70000;
  localparam logic signed [17:0] VC = 18'sd1234;
  localparam logic signed [17:0] VD = 18'sd99;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [17:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               pdm_clk;
  logic               pdm_data;
  logic               underrun;

  pdm_modulator #(
    .CLK_DIV(CLK_DIV),
    .OSR    (OSR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pdm_clk (pdm_clk),
    .pdm_data(pdm_data),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_rng(input string name, input int act,
                           input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi)
      passes++;
    else
      $display("FAIL %s: got %0d, expected %0d..%0d",
               name, act, lo, hi);
  endtask

  // Reference model: m_cyc counts enabled edges since the last
  // disable/reset; bit index and phase follow from plain division.
  int m_cyc, m_i1, m_i2, m_bit, m_cur, m_hold, m_hf, m_frame;
  bit m_tick;

  function automatic int sat24(input longint v);
    if (v > 64'sd8388607)
      return 8388607;
    if (v < -64'sd8388608)
      return -8388608;
    return int'(v);
  endfunction

  task automatic model_reset();
    m_cyc  = 0;
    m_i1   = 0;
    m_i2   = 0;
    m_bit  = 0;
    m_cur  = 0;
    m_hold = 0;
    m_hf   = 0;
    m_tick = 0;
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    int old_hf;
    int fb;
    if (!rst) begin
      model_reset();
    end else begin
      old_hf = m_hf;
      m_tick = 0;
      if (!enable) begin
        m_cyc = 0;
        m_i1  = 0;
        m_i2  = 0;
        m_bit = 0;
      end else begin
        if (m_cyc % CLK_DIV == CLK_DIV - 1) begin
          fb      = m_bit ? FS : -FS;
          m_i1    = sat24(longint'(m_i1) + m_cur - fb);
          m_i2    = sat24(longint'(m_i2) + m_i1 - fb);
          m_bit   = (m_i2 >= 0) ? 1 : 0;
          m_tick  = 1;
          m_frame = m_cyc / FRAME;
          if ((m_cyc / CLK_DIV) % OSR == OSR - 1 && old_hf != 0) begin
            m_cur = m_hold;
            m_hf  = 0;
          end
        end
        m_cyc++;
      end
      if (in_valid && old_hf == 0) begin
        m_hold = int'(in_data);
        m_hf   = 1;
      end
    end
  end

  function automatic logic [21:0] model_out();
    logic pclk;
    logic und;
    logic [17:0] c;
    pclk = (m_cyc % CLK_DIV) >= CLK_DIV / 2;
    und  = enable && rst && m_hf == 0 &&
           (m_cyc % CLK_DIV == CLK_DIV - 1) &&
           ((m_cyc / CLK_DIV) % OSR == OSR - 1);
    c    = 18'(m_cur);
    return {pclk, m_bit[0], und, (m_hf == 0), c};
  endfunction

  int ones [8];
  int und_cnt;
  bit cnt_en = 0;

  always @(negedge clk) begin
    check("cycle", {pdm_clk, pdm_data, underrun, in_ready, dut.cur},
          model_out());
    if (cnt_en && m_tick && m_frame < 8)
      ones[m_frame] += int'(pdm_data);
    if (cnt_en && underrun)
      und_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic dc_test(input logic signed [17:0] val,
                         input int first, input int target,
                         input string name);
    rst      = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int f = 0; f < 8; f++)
      ones[f] = 0;
    und_cnt  = 0;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = val;
    cnt_en   = 1'b1;
    repeat (6 * FRAME) step();
    cnt_en   = 1'b0;
    in_valid = 1'b0;
    for (int f = first; f < 6; f++)
      check_rng(name, ones[f], target - 2, target + 2);
    check({name, "_underrun"}, und_cnt, 0);
  endtask

  typedef struct {
    logic        rst_v;
    logic        en;
    logic        vld;
    logic [17:0] data;
    logic        rdy;
    logic        pclk;
    logic        pdat;
    logic        und;
  } vec_t;

  initial begin
    vec_t vecs [10];
    int   n;
    int   dens;
    int   npulse;
    int   last_k;
    logic prev_und;

    rst      = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 18'h12345, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rst      = vecs[i].rst_v;
      enable   = vecs[i].en;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].data;
      step();
      check($sformatf("vec%0d", i),
            {in_ready, pdm_clk, pdm_data, underrun},
            {vecs[i].rdy, vecs[i].pclk, vecs[i].pdat, vecs[i].und});
    end

    // Randomized run: alternate sparse and dense sample offers with
    // occasional enable drops; the per-cycle checker compares it all.
    rst    = 1'b1;
    enable = 1'b1;
    for (int blk = 0; blk < 10; blk++) begin
      dens = (blk % 2 == 1) ? 4 : 1200;
      for (int c = 0; c < 2048; c++) begin
        in_valid = (($urandom % dens) == 0);
        in_data  = 18'($urandom);
        if (enable && ($urandom % 2500) == 0)
          enable = 1'b0;
        else if (!enable && ($urandom % 16) == 0)
          enable = 1'b1;
        step();
      end
    end

    dc_test(18'sd0, 0, 32, "dc_zero");
    dc_test(18'sd65536, 1, 48, "dc_half");

    // Backpressure: A then B offered back to back.
    rst      = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = VA;
    step();
    check("bp_a_taken", in_ready, 1'b0);
    in_data = VB;
    n = 0;
    while (!in_ready && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("bp_a_wait", n, FRAME - 1);
    check("bp_cur_a", dut.cur, VA);
    step();
    check("bp_b_taken", in_ready, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("bp_b_wait", n, FRAME - 1);
    check("bp_cur_b", dut.cur, VB);

    // Starved input: one pulse per boundary, cur retained.
    npulse   = 0;
    last_k   = 0;
    prev_und = 1'b0;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      step();
      if (underrun) begin
        check("und_width", prev_und, 1'b0);
        check("und_cur_kept", dut.cur, VB);
        if (npulse == 0)
          check("und_first", k, FRAME - 1);
        else
          check("und_gap", k - last_k, FRAME);
        npulse++;
        last_k = k;
      end
      prev_und = underrun;
    end
    check("und_count", npulse, 3);

    // Enable drop in the high half of bit 20.
    repeat (20 * CLK_DIV + 5) step();
    check("en_pre_clk_high", pdm_clk, 1'b1);
    enable = 1'b0;
    step();
    check("en_off_outs", {pdm_clk, pdm_data, underrun}, 3'b000);
    check("en_off_cur", dut.cur, VB);
    in_valid = 1'b1;
    in_data  = VC;
    step();
    check("en_off_accept", in_ready, 1'b0);
    in_valid = 1'b0;
    enable   = 1'b1;
    repeat (CLK_DIV / 2 - 1) step();
    check("re_en_clk_low", pdm_clk, 1'b0);
    step();
    check("re_en_clk_high", pdm_clk, 1'b1);
    n = CLK_DIV / 2;
    while (!in_ready && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("re_en_frame", n, FRAME);
    check("re_en_cur", dut.cur, VC);

    // Asynchronous reset mid-frame with the holding register full.
    in_valid = 1'b1;
    in_data  = VD;
    n = 0;
    while (!(pdm_clk && pdm_data && !in_ready) && n < 4 * FRAME) begin
      step();
      n++;
    end
    check("rst_pre_state", {pdm_clk, pdm_data, in_ready}, 3'b110);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_outs", {pdm_clk, pdm_data, in_ready, underrun},
          4'b0010);
    check("rst_async_cur", dut.cur, 18'd0);
    step();
    rst = 1'b1;
    step();
    check("rst_release", {pdm_clk, in_ready}, 2'b01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
